// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg -- shared definitions for the FPU issue controller.
//   * funct7 opcode constants for the supported operations
//   * issue FSM state encoding
//   * bit positions of the IEEE exception flags {NV,DZ,OF,UF,NX}
//   * helper deciding whether an opcode is handled by the FPU pipeline
// ---------------------------------------------------------------------------
package fpu_pkg;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0000100;
    localparam logic [6:0] F7_MUL = 7'b0001000;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    // Flags reported for an opcode the pipeline does not implement.
    localparam logic [4:0] FLAGS_ILLEGAL = 5'(1 << FLAG_NV);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } fpu_state_e;

    function automatic logic is_supported(input logic [6:0] funct7);
        return (funct7 == F7_ADD) || (funct7 == F7_SUB) || (funct7 == F7_MUL);
    endfunction

endpackage

// File: rtl/fpu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// fpu_issue_ctrl -- single-outstanding issue controller for a fixed-latency
// FPU pipeline instantiated by the parent.
//
// Parameters
//   RES_LAT  : clock edges from the first EXEC cycle to a valid fpu_result
//   FLAG_LAT : clock edges from the first EXEC cycle to a valid fpu_flags
//              (FLAG_LAT >= RES_LAT, FLAG_LAT <= 8 for the 3-bit counter)
//
// Ports
//   clk, nrst                 clock, asynchronous active-low reset
//   req_valid/req_ready       request handshake
//   req_op1/op2/frm/funct7/tag  request payload
//   fpu_fp1/fp2/frm/funct7    operands held steady for the FPU
//   fpu_result/fpu_flags      FPU outputs, sampled at fixed latencies
//   resp_valid/resp_ready     response handshake
//   resp_result/flags/tag     captured response
//   fflags, fflags_clr        accrued sticky flags and their clear
//
// Build option: define FPU_ISSUE_FLAG_ACCRUE_EN to build the sticky flag
// accumulator; otherwise fflags is tied to zero.
// ---------------------------------------------------------------------------
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int RES_LAT  = 2,
    parameter int FLAG_LAT = 3
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_op1,
    input  logic [31:0] req_op2,
    input  logic [2:0]  req_frm,
    input  logic [6:0]  req_funct7,
    input  logic [4:0]  req_tag,
    output logic [31:0] fpu_fp1,
    output logic [31:0] fpu_fp2,
    output logic [2:0]  fpu_frm,
    output logic [6:0]  fpu_funct7,
    input  logic [31:0] fpu_result,
    input  logic [4:0]  fpu_flags,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic [4:0]  resp_flags,
    output logic [4:0]  resp_tag,
    output logic [4:0]  fflags,
    input  logic        fflags_clr
);

    // Counter holds k-1 during EXEC cycle k, so cycle k ends when it equals k-1.
    localparam logic [2:0] RES_LAST  = 3'(RES_LAT - 1);
    localparam logic [2:0] FLAG_LAST = 3'(FLAG_LAT - 1);

    fpu_state_e  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        accept;
    logic        handshake;

    logic [31:0] fp1_q, fp2_q, result_q;
    logic [2:0]  frm_q;
    logic [6:0]  funct7_q;
    logic [4:0]  tag_q, flags_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        handshake  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = 3'd0;
                    state_d = is_supported(req_funct7) ? ST_EXEC : ST_RESP;
                end
            end
            ST_EXEC: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == FLAG_LAST) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    handshake = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operands are only rewritten on accept, so the FPU sees stable inputs
    // across its whole latency and while the response waits.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fp1_q    <= '0;
            fp2_q    <= '0;
            frm_q    <= '0;
            funct7_q <= '0;
            tag_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else if (accept) begin
            fp1_q    <= req_op1;
            fp2_q    <= req_op2;
            frm_q    <= req_frm;
            funct7_q <= req_funct7;
            tag_q    <= req_tag;
            if (!is_supported(req_funct7)) begin
                result_q <= 32'h0;
                flags_q  <= FLAGS_ILLEGAL;
            end
        end else if (state_q == ST_EXEC) begin
            if (cnt_q == RES_LAST) begin
                result_q <= fpu_result;
            end
            if (cnt_q == FLAG_LAST) begin
                flags_q <= fpu_flags;
            end
        end
    end

    assign fpu_fp1     = fp1_q;
    assign fpu_fp2     = fp2_q;
    assign fpu_frm     = frm_q;
    assign fpu_funct7  = funct7_q;
    assign resp_result = result_q;
    assign resp_flags  = flags_q;
    assign resp_tag    = tag_q;

`ifdef FPU_ISSUE_FLAG_ACCRUE_EN
    logic [4:0] fflags_q;

    // A clear coinciding with a handshake keeps only the new response's flags.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fflags_q <= '0;
        end else if (fflags_clr && handshake) begin
            fflags_q <= flags_q;
        end else if (fflags_clr) begin
            fflags_q <= '0;
        end else if (handshake) begin
            fflags_q <= fflags_q | flags_q;
        end
    end

    assign fflags = fflags_q;
`else
    logic unused_accrue;
    assign unused_accrue = fflags_clr ^ handshake;
    assign fflags        = 5'b0;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fpu_issue_ctrl -- directed self-checking bench for fpu_issue_ctrl.
// The bench plays the FPU: it presents the hand-computed result only in the
// EXEC cycle where it must be sampled and garbage in all other cycles.
// ---------------------------------------------------------------------------
module tb_fpu_issue_ctrl;

    localparam int RES_LAT  = 2;
    localparam int FLAG_LAT = 3;

    logic        clk = 1'b0;
    logic        nrst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_op1, req_op2;
    logic [2:0]  req_frm;
    logic [6:0]  req_funct7;
    logic [4:0]  req_tag;
    logic [31:0] fpu_fp1, fpu_fp2;
    logic [2:0]  fpu_frm;
    logic [6:0]  fpu_funct7;
    logic [31:0] fpu_result;
    logic [4:0]  fpu_flags;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic [4:0]  resp_flags;
    logic [4:0]  resp_tag;
    logic [4:0]  fflags;
    logic        fflags_clr;

    int          n_vec = 0;
    int          n_err = 0;
    logic [4:0]  model_fflags = 5'b0;

    always #5 clk = ~clk;

    fpu_issue_ctrl #(.RES_LAT(RES_LAT), .FLAG_LAT(FLAG_LAT)) dut (
        .clk(clk), .nrst(nrst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2), .req_frm(req_frm),
        .req_funct7(req_funct7), .req_tag(req_tag),
        .fpu_fp1(fpu_fp1), .fpu_fp2(fpu_fp2), .fpu_frm(fpu_frm),
        .fpu_funct7(fpu_funct7),
        .fpu_result(fpu_result), .fpu_flags(fpu_flags),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_flags(resp_flags), .resp_tag(resp_tag),
        .fflags(fflags), .fflags_clr(fflags_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction; hold = extra RESP cycles with resp_ready low.
    task automatic run_op(input string name, input logic [6:0] f7,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] frm, input logic [4:0] tag,
                          input logic [31:0] res, input logic [4:0] flg,
                          input int hold, input logic clr_hs);
        logic        sup;
        logic [31:0] exp_res;
        logic [4:0]  exp_flg;
        sup     = (f7 == 7'b0000000) || (f7 == 7'b0000100) || (f7 == 7'b0001000);
        exp_res = sup ? res : 32'h0;
        exp_flg = sup ? flg : 5'b10000;

        chk({name, ".req_ready_idle"}, 32'(req_ready), 32'd1);
        req_op1 = a; req_op2 = b; req_frm = frm; req_funct7 = f7; req_tag = tag;
        req_valid = 1'b1;
        fpu_result = ~res;
        fpu_flags  = ~flg;
        tick();
        // Scramble the request bus so the DUT must have registered it.
        req_valid = 1'b0;
        req_op1 = 32'h12345678; req_op2 = 32'h9ABCDEF0; req_frm = 3'd7;
        req_funct7 = 7'h7F; req_tag = 5'h1F;
        chk({name, ".fpu_fp1"}, fpu_fp1, a);
        chk({name, ".fpu_fp2"}, fpu_fp2, b);
        chk({name, ".fpu_frm_f7"}, {22'b0, fpu_frm, fpu_funct7}, {22'b0, frm, f7});

        if (sup) begin
            for (int k = 1; k <= FLAG_LAT; k++) begin
                chk({name, ".busy"}, {30'b0, resp_valid, req_ready}, 32'd0);
                fpu_result = (k == RES_LAT)  ? res : ~res;
                fpu_flags  = (k == FLAG_LAT) ? flg : ~flg;
                tick();
            end
            fpu_result = ~res;
            fpu_flags  = ~flg;
        end

        chk({name, ".resp_valid"}, 32'(resp_valid), 32'd1);
        chk({name, ".resp_result"}, resp_result, exp_res);
        chk({name, ".resp_flags_tag"}, {22'b0, resp_flags, resp_tag}, {22'b0, exp_flg, tag});

        // A competing request offered while the response waits must be ignored.
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            tick();
            chk({name, ".hold_state"}, {30'b0, resp_valid, req_ready}, 32'd2);
            chk({name, ".hold_result"}, resp_result, exp_res);
            chk({name, ".hold_fp1"}, fpu_fp1, a);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        fflags_clr = clr_hs;
        tick();
        resp_ready = 1'b0;
        fflags_clr = 1'b0;
`ifdef FPU_ISSUE_FLAG_ACCRUE_EN
        model_fflags = clr_hs ? exp_flg : (model_fflags | exp_flg);
`endif
        chk({name, ".after_hs"}, {30'b0, resp_valid, req_ready}, 32'd1);
        chk({name, ".fflags"}, 32'(fflags), 32'(model_fflags));
        $display("%s: f7=%b tag=%0d result=%h flags=%b fflags=%b", name, f7, tag,
                 resp_result, resp_flags, fflags);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        nrst = 1'b0;
        req_valid = 1'b0; req_op1 = '0; req_op2 = '0; req_frm = '0;
        req_funct7 = '0; req_tag = '0;
        fpu_result = 32'hDEADBEEF; fpu_flags = 5'b11111;
        resp_ready = 1'b0; fflags_clr = 1'b0;
        #12;
        chk("reset.outputs", {resp_result ^ fpu_fp1 ^ fpu_fp2}, 32'h0);
        chk("reset.ctrl", {7'b0, resp_valid, resp_flags, resp_tag, fflags, fpu_frm, fpu_funct7},
            32'h0);
        #4 nrst = 1'b1;
        tick();
        chk("reset.req_ready", 32'(req_ready), 32'd1);

        run_op("add",  7'b0000000, 32'h3F800000, 32'h40000000, 3'd0, 5'd3,
               32'h40400000, 5'b00000, 0, 1'b0);
        run_op("mul",  7'b0001000, 32'h40000000, 32'h40400000, 3'd1, 5'd21,
               32'h40C00000, 5'b00000, 0, 1'b0);
        run_op("inf_minus_inf", 7'b0000000, 32'h7F800000, 32'hFF800000, 3'd0, 5'd7,
               32'h7FC00000, 5'b10000, 0, 1'b0);
        tick();
        chk("fflags.sticky", 32'(fflags), 32'(model_fflags));
        fflags_clr = 1'b1;
        tick();
        fflags_clr = 1'b0;
        model_fflags = 5'b0;
        chk("fflags.cleared", 32'(fflags), 32'd0);

        run_op("unsupported", 7'b0101100, 32'h3F800000, 32'h3F800000, 3'd2, 5'd9,
               32'h0, 5'b10000, 0, 1'b0);
        run_op("sub_hold", 7'b0000100, 32'h40400000, 32'h3F800000, 3'd0, 5'd12,
               32'h40000000, 5'b00000, 5, 1'b0);
        run_op("add_nx_clr_hs", 7'b0000000, 32'h3F800000, 32'h33800000, 3'd0, 5'd30,
               32'h3F800000, 5'b00001, 0, 1'b1);

        // Reset during EXEC cycle 1: no response, no accrual, outputs cleared.
        req_op1 = 32'h40A00000; req_op2 = 32'h40A00000; req_frm = 3'd0;
        req_funct7 = 7'b0001000; req_tag = 5'd5; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        nrst = 1'b0;
        #2;
        model_fflags = 5'b0;
        chk("midexec_reset.data", resp_result ^ fpu_fp1 ^ fpu_fp2, 32'h0);
        chk("midexec_reset.ctrl",
            {7'b0, resp_valid, resp_flags, resp_tag, fflags, fpu_frm, fpu_funct7}, 32'h0);
        #4 nrst = 1'b1;
        for (int i = 0; i < FLAG_LAT + 2; i++) begin
            tick();
            chk("midexec_reset.no_resp", {30'b0, resp_valid, req_ready}, 32'd1);
        end
        run_op("after_reset", 7'b0000000, 32'h3F800000, 32'h40000000, 3'd0, 5'd17,
               32'h40400000, 5'b00000, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have parameter RES_LAT, default 2, meaning clock edges from the first EXEC cycle to a valid fpu_result.
REQ-002 SHALL have parameter FLAG_LAT, default 3, meaning clock edges from the first EXEC cycle to a valid fpu_flags; FLAG_LAT >= RES_LAT.
REQ-003 SHALL have ports:
 clk  in  1  clock
 nrst  in  1  reset, asynchronous, active-low
 req_valid  in  1  request offered
 req_ready  out  1  request accepted when high with req_valid
 req_op1, req_op2  in  32  IEEE-754 single operands
 req_frm  in  3  rounding mode
 req_funct7  in  7  op code: ADD 7'b0000000, SUB 7'b0000100, MUL 7'b0001000
 req_tag  in  5  requester tag
 fpu_fp1, fpu_fp2  out  32  operands to the FPU pipeline
 fpu_frm  out  3  rounding mode to the FPU
 fpu_funct7  out  7  op code to the FPU
 fpu_result  in  32  FPU result
 fpu_flags  in  5  FPU flags {NV,DZ,OF,UF,NX}
 resp_valid  out  1  response available
 resp_ready  in  1  response consumed when high with resp_valid
 resp_result  out  32  captured result
 resp_flags  out  5  captured flags
 resp_tag  out  5  tag of the request
 fflags  out  5  accrued sticky flags
 fflags_clr  in  1  clear accrued flags

Function
REQ-004 SHALL allow one outstanding operation; the FPU reads operands combinationally in late stages, so fpu_fp1/fpu_fp2/fpu_frm/fpu_funct7 SHALL stay constant from launch until the response handshake and after it until the next accept.
REQ-005 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-006 IDLE: req_ready=1; on req_valid, register operands, frm, funct7, tag; clear cycle counter; go to EXEC for a supported funct7, else to RESP.
REQ-007 Unsupported funct7: resp_result=32'h0 and resp_flags=5'b10000; no EXEC cycles; fpu_* outputs still update.
REQ-008 EXEC: 3-bit counter increments each cycle; on the edge ending EXEC cycle RES_LAT capture fpu_result; on the edge ending EXEC cycle FLAG_LAT capture fpu_flags and go to RESP.
REQ-009 RESP: resp_valid=1 with result/flags/tag stable; req_ready=0; on resp_ready go to IDLE. No same-cycle accept of a new request.
REQ-010 req_ready SHALL be 0 in EXEC and RESP; req_valid in those states SHALL be ignored.
REQ-011 resp_valid SHALL be 0 outside RESP; resp_ready outside RESP SHALL be ignored.
REQ-012 Latency, accept edge to resp_valid high: FLAG_LAT+1 cycles for supported ops, 1 cycle for unsupported ops.

Reset
REQ-013 On nrst low, at any time including mid-EXEC or mid-RESP: state IDLE, counter 0, all fpu_*, resp_* and fflags outputs 0, resp_valid 0; req_ready 1 after release.
REQ-014 An operation interrupted by reset SHALL produce no response and SHALL NOT accrue flags.

Configuration
REQ-015 With FPU_ISSUE_FLAG_ACCRUE_EN defined: on each response handshake, fflags <= fflags | resp_flags; fflags_clr clears fflags to 0; when clear and handshake coincide, fflags <= resp_flags.
REQ-016 Without FPU_ISSUE_FLAG_ACCRUE_EN: fflags is constant 0, fflags_clr is ignored, and no accrual register is built.

Structure
REQ-017 Funct7 opcode constants, the FSM state enum and the flag bit positions (NV=4, DZ=3, OF=2, UF=1, NX=0) SHALL be in shared package fpu_pkg.
REQ-018 The block SHALL be a single module with no sub-modules; the FPU is instantiated by the parent.

Verification
REQ-019 ADD 0x3F800000 + 0x40000000 -> resp_result 0x40400000, resp_flags 0, resp_valid at accept+FLAG_LAT+1.
REQ-020 MUL 0x40000000 * 0x40400000 -> 0x40C00000, flags 0, tag echoed.
REQ-021 ADD 0x7F800000 + 0xFF800000 -> resp_flags[4]=1; with macro, fflags=5'b10000 until fflags_clr, then 0.
REQ-022 funct7 7'b0101100 -> resp_valid one cycle after accept, result 0, flags 5'b10000.
REQ-023 resp_ready held low for 5 cycles in RESP -> response stable, req_ready 0, fpu_* operands unchanged; second request accepted only after the handshake.
REQ-024 nrst asserted in EXEC cycle 1 -> all outputs 0, no response; next request completes normally.
